alu_serial_seq: RTL and testbench

//  Bit-serial ALU sequencer. Drives the 1-bit slice function (and/or/add/less with
//  b-invert) one bit per clock, LSB first, over a WIDTH-bit operand pair.

---
 rtl/alu_serial_seq.sv | 155 +++++++++++++++
 tb/tb_alu_serial_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: evaluates one ALU slice per clock, LSB first, over a
// WIDTH-bit operand pair, with a start/done handshake and SLT/overflow handling.
module alu_serial_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    F_AND = 2'b00,
    F_OR  = 2'b01,
    F_ADD = 2'b10,
    F_SLT = 2'b11
  } func_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic [CNT_W-1:0] count_q;
  logic             sum_msb_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic             ovf_q;

  func_t            func;
  logic             slice_a;
  logic             slice_bi;
  logic             slice_sum;
  logic             slice_cout;
  logic             slice_r;
  logic [WIDTH-1:0] result_fix_d;

  assign func = func_t'(op_q[1:0]);

  // Operands are shifted right each RUN cycle, so the active slice always sits at bit 0.
  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    slice_a    = a_q[0];
    slice_bi   = b_q[0] ^ op_q[2];
    slice_sum  = slice_a ^ slice_bi ^ carry_q;
    slice_cout = (slice_a & slice_bi) | (carry_q & (slice_a ^ slice_bi));
    slice_r    = 1'b0;
    unique case (func)
      F_AND:   slice_r = slice_a & slice_bi;
      F_OR:    slice_r = slice_a | slice_bi;
      F_ADD:   slice_r = slice_sum;
      F_SLT:   slice_r = 1'b0;
      default: slice_r = 1'b0;
    endcase
  end

  // SLT takes the raw sign of a - b (no overflow correction) as its only set bit.
  always_comb begin
    result_fix_d = result_q;
    if (func == F_SLT) begin
      result_fix_d[0] = sum_msb_q;
    end
  end

  // NOTE: all state here uses non-blocking assignments so each slice sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      sum_msb_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= alu_op;
            carry_q <= alu_op[2];
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          carry_q  <= slice_cout;
          result_q <= {slice_r, result_q[WIDTH-1:1]};
          count_q  <= count_q + CNT_W'(1);
          if (count_q == LAST_BIT) begin
            sum_msb_q <= slice_sum;
            ovf_q     <= (func == F_ADD) & (carry_q ^ slice_cout);
            state_q   <= S_FIX;
          end
        end

        S_FIX: begin
          result_q <= result_fix_d;
          zero_q   <= (result_fix_d == '0);
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: stimulus pushes expected responses, a
// monitor pops and compares them on every done pulse.
module tb_alu_serial_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          accept_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_serial_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.res);
        check("zero", {31'd0, zero}, {31'd0, mon_e.zero});
        check("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
        check("latency", edge_cnt, mon_e.accept_edge + WIDTH + 1);
      end
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    else check("busy_in_done", {31'd0, busy}, 32'd0);
  endtask

  // Drive start for one cycle from IDLE and push the expected response.
  task automatic launch(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic ez, input logic eo, input bit expect_done);
    exp_t e;
    @(negedge clk);
    alu_op = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    if (expect_done) begin
      e.res = er;
      e.zero = ez;
      e.ovf = eo;
      e.accept_edge = edge_cnt + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    alu_op = ~op;
    a      = ~av;
    b      = ~bv;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic ez, input logic eo);
    launch(op, av, bv, er, ez, eo, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // op, a, b, result, zero, overflow
    run_op(3'b010, 32'd5,        32'd3,    32'd8,        1'b0, 1'b0);
    run_op(3'b110, 32'd3,        32'd5,    32'hFFFFFFFE, 1'b0, 1'b0);
    run_op(3'b110, 32'd5,        32'd5,    32'd0,        1'b1, 1'b0);
    run_op(3'b111, 32'd3,        32'd5,    32'd1,        1'b0, 1'b0);
    run_op(3'b111, 32'd5,        32'd3,    32'd0,        1'b1, 1'b0);
    run_op(3'b111, 32'hFFFFFFFF, 32'd1,    32'd1,        1'b0, 1'b0);
    run_op(3'b010, 32'h7FFFFFFF, 32'd1,    32'h80000000, 1'b0, 1'b1);
    run_op(3'b000, 32'h0000F0F0, 32'hFF00, 32'h0000F000, 1'b0, 1'b0);
    run_op(3'b001, 32'h0000F0F0, 32'hFF00, 32'h0000FFF0, 1'b0, 1'b0);
    run_op(3'b010, 32'hFFFFFFFF, 32'd1,    32'd0,        1'b1, 1'b0);
    run_op(3'b110, 32'h80000000, 32'd1,    32'h7FFFFFFF, 1'b0, 1'b1);

    // Second start mid-operation is ignored; only the first result appears.
    launch(3'b010, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    alu_op = 3'b010; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Reset mid-operation clears outputs at once and produces no done.
    launch(3'b010, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op(3'b010, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
